// File: rtl/csync_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csync_encoder_pkg
//  Description : Shared definitions for the composite-sync encoder.
//                Holds the CSYNC mode encodings and the default widths.
//                No ports; imported by csync_encoder and its sub-module.
//  Revision    : 1.0 - initial release
// ============================================================================
package csync_encoder_pkg;

  // Default width of the line/pulse counters (max line 4095 PCLKs).
  localparam int CSYNC_H_BITS_DEFAULT     = 12;
  // Default number of consecutive equal line lengths needed for lock.
  localparam int CSYNC_LOCK_LINES_DEFAULT = 2;

  // Encodings of the 2-bit mode input. The reserved code behaves as AND.
  typedef enum logic [1:0] {
    CSYNC_MODE_AND  = 2'd0,
    CSYNC_MODE_XOR  = 2'd1,
    CSYNC_MODE_SERR = 2'd2,
    CSYNC_MODE_RSVD = 2'd3
  } csync_mode_e;

endpackage
`default_nettype wire

// File: rtl/csync_encoder_sync_meas.sv
`default_nettype none
// ============================================================================
//  Module      : csync_encoder_sync_meas
//  Description : Input registers, HSYNC edge detection and line measurement.
//                Counts PCLKs per line and HSYNC low width, and decides lock
//                once LOCK_LINES consecutive line lengths repeat.
//  Ports       : clk        in   pixel clock, posedge
//                reset      in   synchronous active-high reset
//                hsync_in   in   active-low HSYNC
//                vsync_in   in   active-low VSYNC
//                hs_l       out  registered HSYNC
//                vs_l       out  registered VSYNC
//                line_start out  HSYNC falling edge seen this cycle
//                h_ctr      out  PCLKs since the last line start (saturating)
//                h_total    out  last measured line length
//                hs_width   out  last measured HSYNC low width
//                locked     out  measurement stable
//  Revision    : 1.0 - initial release
// ============================================================================
module csync_encoder_sync_meas
  import csync_encoder_pkg::*;
#(
  parameter int H_BITS     = CSYNC_H_BITS_DEFAULT,
  parameter int LOCK_LINES = CSYNC_LOCK_LINES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic              hs_l,
  output logic              vs_l,
  output logic              line_start,
  output logic [H_BITS-1:0] h_ctr,
  output logic [H_BITS-1:0] h_total,
  output logic [H_BITS-1:0] hs_width,
  output logic              locked
);

  localparam int                MC_BITS    = $clog2(LOCK_LINES + 1);
  localparam logic [H_BITS-1:0] C_H_MAX    = '1;
  localparam logic [MC_BITS-1:0] C_LOCK_CNT = MC_BITS'(LOCK_LINES);

  logic               r_hs_l;
  logic               r_vs_l;
  logic               r_hs_prev;
  logic [H_BITS-1:0]  r_h_ctr;
  logic [H_BITS-1:0]  r_h_total;
  logic [H_BITS-1:0]  r_hs_width;
  logic [MC_BITS-1:0] r_match_cnt;
  logic               r_ovf;

  logic               w_line_start;
  logic               w_hs_end;
  logic               w_ctr_at_max;
  logic [H_BITS-1:0]  w_ctr_plus1;
  logic               w_overflow;

  assign w_line_start = r_hs_prev & ~r_hs_l;
  assign w_hs_end     = ~r_hs_prev & r_hs_l;
  assign w_ctr_at_max = (r_h_ctr == C_H_MAX);
  // Saturating "count including this cycle"; also used for the captures so
  // an over-long line reports the maximum rather than wrapping to 0.
  assign w_ctr_plus1  = w_ctr_at_max ? C_H_MAX : (r_h_ctr + H_BITS'(1));
  // A line that keeps running past the counter range can no longer be
  // measured, so lock is abandoned at once instead of at the next edge.
  assign w_overflow   = w_ctr_at_max & ~w_line_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      // Input registers idle high so no false edge appears after reset.
      r_hs_l      <= 1'b1;
      r_vs_l      <= 1'b1;
      r_hs_prev   <= 1'b1;
      r_h_ctr     <= '0;
      r_h_total   <= '0;
      r_hs_width  <= '0;
      r_match_cnt <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_hs_l    <= hsync_in;
      r_vs_l    <= vsync_in;
      r_hs_prev <= r_hs_l;
      if (w_line_start) begin
        r_h_ctr   <= '0;
        r_h_total <= w_ctr_plus1;
        r_ovf     <= 1'b0;
        if (w_ctr_plus1 == r_h_total) begin
          if (r_match_cnt != C_LOCK_CNT) begin
            r_match_cnt <= r_match_cnt + MC_BITS'(1);
          end
        end else begin
          r_match_cnt <= '0;
        end
      end else begin
        r_h_ctr <= w_ctr_plus1;
        if (w_overflow) begin
          r_ovf       <= 1'b1;
          r_match_cnt <= '0;
        end
        if (w_hs_end) begin
          r_hs_width <= w_ctr_plus1;
        end
      end
    end
  end

  assign hs_l       = r_hs_l;
  assign vs_l       = r_vs_l;
  assign line_start = w_line_start;
  assign h_ctr      = r_h_ctr;
  assign h_total    = r_h_total;
  assign hs_width   = r_hs_width;
  assign locked     = (r_match_cnt == C_LOCK_CNT) & (r_hs_width < r_h_total) & ~r_ovf;

endmodule
`default_nettype wire

// File: rtl/csync_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : csync_encoder
//  Description : Merges active-low HSYNC/VSYNC into an active-low composite
//                sync. AND / XOR combining, or serrated vsync when the line
//                measurement is locked. Publishes line length/HSYNC width.
//  Ports       : PCLK      in   pixel clock, posedge
//                reset     in   synchronous active-high reset
//                HSYNC_in  in   active-low HSYNC
//                VSYNC_in  in   active-low VSYNC
//                mode      in   0=AND 1=XOR 2=SERR 3=AND
//                CSYNC_out out  active-low composite sync
//                locked    out  line measurement stable
//                h_total   out  measured line length in PCLKs
//                hs_width  out  measured HSYNC low width in PCLKs
//  Revision    : 1.0 - initial release
// ============================================================================
module csync_encoder
  import csync_encoder_pkg::*;
#(
  parameter int H_BITS     = CSYNC_H_BITS_DEFAULT,
  parameter int LOCK_LINES = CSYNC_LOCK_LINES_DEFAULT
) (
  input  logic              PCLK,
  input  logic              reset,
  input  logic              HSYNC_in,
  input  logic              VSYNC_in,
  input  logic [1:0]        mode,
  output logic              CSYNC_out,
  output logic              locked,
  output logic [H_BITS-1:0] h_total,
  output logic [H_BITS-1:0] hs_width
);

  logic              w_hs_l;
  logic              w_vs_l;
  logic              w_line_start;
  logic [H_BITS-1:0] w_h_ctr;
  logic [H_BITS-1:0] w_h_total;
  logic [H_BITS-1:0] w_hs_width;
  logic              w_locked;

  logic              r_vs_line;
  logic              r_csync;

  logic              w_xor_level;
  logic [H_BITS-1:0] w_serr_thresh;
  logic              w_serr_high;
  logic              w_csync_next;

  csync_encoder_sync_meas #(
    .H_BITS     (H_BITS),
    .LOCK_LINES (LOCK_LINES)
  ) u_sync_meas (
    .clk        (PCLK),
    .reset      (reset),
    .hsync_in   (HSYNC_in),
    .vsync_in   (VSYNC_in),
    .hs_l       (w_hs_l),
    .vs_l       (w_vs_l),
    .line_start (w_line_start),
    .h_ctr      (w_h_ctr),
    .h_total    (w_h_total),
    .hs_width   (w_hs_width),
    .locked     (w_locked)
  );

  assign w_xor_level   = ~(w_hs_l ^ w_vs_l);
  // Serration pulse occupies the last hs_width PCLKs of each vsync line.
  // Comparing against h_ctr+1 makes the registered output rise exactly
  // hs_width cycles before the next line start. Only used while locked,
  // which guarantees hs_width < h_total so the subtraction cannot wrap.
  assign w_serr_thresh = w_h_total - w_hs_width;
  assign w_serr_high   = (({1'b0, w_h_ctr} + (H_BITS + 1)'(1)) >= {1'b0, w_serr_thresh});

  always_comb begin
    w_csync_next = w_hs_l & w_vs_l;
    case (mode)
      CSYNC_MODE_XOR: begin
        w_csync_next = w_xor_level;
      end
      CSYNC_MODE_SERR: begin
        if (!w_locked) begin
          w_csync_next = w_xor_level;
        end else if (w_line_start) begin
          // Every line begins low regardless of the vs_line value about to
          // be captured; HS_L is also low here, so both paths agree.
          w_csync_next = 1'b0;
        end else if (r_vs_line) begin
          w_csync_next = w_serr_high;
        end else begin
          w_csync_next = w_hs_l;
        end
      end
      default: begin
        w_csync_next = w_hs_l & w_vs_l;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (reset) begin
      r_vs_line <= 1'b0;
      r_csync   <= 1'b1;
    end else begin
      // Vsync is only recognised at line boundaries so SERR never emits
      // runt pulses from a mid-line VSYNC edge.
      if (w_line_start) begin
        r_vs_line <= ~w_vs_l;
      end
      r_csync <= w_csync_next;
    end
  end

  assign CSYNC_out = r_csync;
  assign locked    = w_locked;
  assign h_total   = w_h_total;
  assign hs_width  = w_hs_width;

endmodule
`default_nettype wire

// File: tb/tb_csync_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csync_encoder
//  Description : Self-checking bench for csync_encoder. A timestamp-based
//                reference model (position of each PCLK within the current
//                line, lengths between HSYNC falls) predicts every output
//                every cycle; directed checks cover the key scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csync_encoder;

  localparam int H_BITS = 12;
  localparam int LOCK   = 2;
  localparam int H_MAX  = (1 << H_BITS) - 1;

  logic              PCLK;
  logic              reset;
  logic              HSYNC_in;
  logic              VSYNC_in;
  logic [1:0]        mode;
  logic              CSYNC_out;
  logic              locked;
  logic [H_BITS-1:0] h_total;
  logic [H_BITS-1:0] hs_width;

  csync_encoder #(
    .H_BITS     (H_BITS),
    .LOCK_LINES (LOCK)
  ) dut (
    .PCLK      (PCLK),
    .reset     (reset),
    .HSYNC_in  (HSYNC_in),
    .VSYNC_in  (VSYNC_in),
    .mode      (mode),
    .CSYNC_out (CSYNC_out),
    .locked    (locked),
    .h_total   (h_total),
    .hs_width  (hs_width)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model state
  int m_lf;      // sample index of the last line start (virtual at reset)
  int m_htot;
  int m_hsw;
  int m_mc;
  bit m_ovf;
  bit m_vsl;
  bit m_cs;

  // Sample history: p1 = previous sample, p0_h = HSYNC of the one before
  bit p1_h, p1_v, p0_h;

  int lowrun      = 0;
  int last_lowrun = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic bit model_locked();
    return (m_mc == LOCK) && (m_hsw < m_htot) && !m_ovf;
  endfunction

  task automatic model_reset(input int s);
    m_lf   = s - 1;
    m_htot = 0;
    m_hsw  = 0;
    m_mc   = 0;
    m_ovf  = 1'b0;
    m_vsl  = 1'b0;
    m_cs   = 1'b1;
  endtask

  // Effect of input sample s (hs, vs; hp = HSYNC one sample earlier) with the
  // mode present when the output register loads.
  task automatic model_step(input int s, input bit hs, input bit vs, input bit hp,
                            input logic [1:0] m);
    int pos, len;
    bit fall, lk;
    pos  = s - m_lf - 1;             // PCLKs elapsed since the line began
    if (pos > H_MAX) pos = H_MAX;
    len  = pos + 1;
    if (len > H_MAX) len = H_MAX;
    fall = hp && !hs;
    lk   = model_locked();

    if (m == 2'd1 || (m == 2'd2 && !lk)) begin
      m_cs = (hs == vs);
    end else if (m == 2'd2) begin
      if (fall)       m_cs = 1'b0;
      else if (m_vsl) m_cs = (len >= (m_htot - m_hsw)); // last hs_width PCLKs high
      else            m_cs = hs;
    end else begin
      m_cs = hs & vs;
    end

    if (fall) begin
      m_mc   = (len == m_htot) ? ((m_mc < LOCK) ? m_mc + 1 : LOCK) : 0;
      m_htot = len;
      m_ovf  = 1'b0;
      m_vsl  = !vs;
      m_lf   = s;
    end else begin
      if (pos == H_MAX) begin
        m_ovf = 1'b1;
        m_mc  = 0;
      end
      if (!hp && hs) m_hsw = len;
    end
  endtask

  // One PCLK: drive at the falling edge, let the DUT clock, compare at the
  // next falling edge.
  task automatic tick(input bit h, input bit v, input bit r);
    HSYNC_in = h;
    VSYNC_in = v;
    reset    = r;
    @(posedge PCLK);
    @(negedge PCLK);
    cyc++;
    if (r) begin
      model_reset(cyc);
      p1_h = 1'b1;
      p1_v = 1'b1;
      p0_h = 1'b1;
    end else begin
      model_step(cyc - 1, p1_h, p1_v, p0_h, mode);
      p0_h = p1_h;
      p1_h = h;
      p1_v = v;
    end
    chk("csync",    32'(CSYNC_out), 32'(m_cs));
    chk("locked",   32'(locked),    32'(model_locked()));
    chk("h_total",  32'(h_total),   32'(m_htot));
    chk("hs_width", 32'(hs_width),  32'(m_hsw));
    if (CSYNC_out === 1'b0) begin
      lowrun++;
    end else begin
      if (lowrun != 0) last_lowrun = lowrun;
      lowrun = 0;
    end
  endtask

  // One line of len PCLKs starting with an HSYNC fall, HSYNC low for w.
  // VSYNC is v0 for the first vsw PCLKs, v1 afterwards.
  task automatic run_line(input int len, input int w, input bit v0, input bit v1, input int vsw);
    for (int i = 0; i < len; i++) begin
      tick(i >= w, (i < vsw) ? v0 : v1, 1'b0);
    end
  endtask

  initial begin
    int len, w, n, sw;
    bit v0, v1;
    mode     = 2'd1;
    HSYNC_in = 1'b1;
    VSYNC_in = 1'b1;
    reset    = 1'b1;
    @(negedge PCLK);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1);
    chk("rst_csync",    32'(CSYNC_out), 32'd1);
    chk("rst_locked",   32'(locked),    32'd0);
    chk("rst_h_total",  32'(h_total),   32'd0);
    chk("rst_hs_width", 32'(hs_width),  32'd0);

    // Standard 858/64 timing, VSYNC inactive, XOR mode.
    for (int i = 0; i < 6; i++) run_line(858, 64, 1'b1, 1'b1, 858);
    chk("std_h_total",  32'(h_total),  32'd858);
    chk("std_hs_width", 32'(hs_width), 32'd64);
    chk("std_locked",   32'(locked),   32'd1);

    // AND mode, 3 vsync lines: solid low, no pulses.
    mode = 2'd0;
    run_line(858, 64, 1'b0, 1'b0, 858);
    run_line(858, 64, 1'b0, 1'b0, 858);
    chk("and_vs_lowrun", 32'(lowrun), 32'd1715);
    run_line(858, 64, 1'b0, 1'b0, 858);
    for (int i = 0; i < 2; i++) run_line(858, 64, 1'b1, 1'b1, 858);

    // SERR, locked, 3 vsync lines: low 794 / high 64 each.
    mode = 2'd2;
    run_line(858, 64, 1'b1, 1'b1, 858);
    run_line(858, 64, 1'b0, 1'b0, 858);
    run_line(858, 64, 1'b0, 1'b0, 858);
    chk("serr_lowrun", 32'(last_lowrun), 32'd794);
    chk("serr_locked", 32'(locked),      32'd1);
    run_line(858, 64, 1'b0, 1'b0, 858);
    run_line(858, 64, 1'b1, 1'b1, 858);

    // SERR, VSYNC falls mid-line: serration starts at the next line only.
    run_line(858, 64, 1'b1, 1'b0, 400);
    run_line(858, 64, 1'b0, 1'b0, 858);
    run_line(858, 64, 1'b0, 1'b1, 300);
    run_line(858, 64, 1'b1, 1'b1, 858);

    // Alternating 858/860: never locks, SERR behaves as XOR.
    for (int i = 0; i < 3; i++) begin
      run_line(858, 64, 1'b1, 1'b0, 500);
      run_line(860, 64, 1'b0, 1'b1, 200);
    end
    chk("alt_locked", 32'(locked), 32'd0);

    // Randomised groups of repeated lines, random modes and VSYNC.
    for (int g = 0; g < 10; g++) begin
      len  = $urandom_range(120, 600);
      w    = $urandom_range(4, len / 4);
      n    = $urandom_range(2, 5);
      mode = 2'($urandom_range(0, 3));
      for (int l = 0; l < n; l++) begin
        v0 = 1'($urandom_range(0, 1));
        v1 = 1'($urandom_range(0, 1));
        sw = $urandom_range(0, len);
        run_line(len, w, v0, v1, sw);
      end
    end

    // HSYNC stuck high: counter saturates, lock is lost.
    mode = 2'd2;
    for (int i = 0; i < 4; i++) run_line(858, 64, 1'b1, 1'b1, 858);
    for (int i = 0; i < 5000; i++) tick(1'b1, 1'b1, 1'b0);
    chk("stuck_locked", 32'(locked), 32'd0);
    run_line(858, 64, 1'b1, 1'b1, 858);
    chk("stuck_h_total", 32'(h_total), 32'd4095);

    // Reset mid-line, then re-lock after LOCK_LINES+1 full lines.
    for (int i = 0; i < 3; i++) run_line(858, 64, 1'b1, 1'b1, 858);
    run_line(300, 64, 1'b0, 1'b0, 300);
    tick(1'b1, 1'b0, 1'b1);
    chk("midrst_csync",    32'(CSYNC_out), 32'd1);
    chk("midrst_locked",   32'(locked),    32'd0);
    chk("midrst_h_total",  32'(h_total),   32'd0);
    chk("midrst_hs_width", 32'(hs_width),  32'd0);
    for (int i = 0; i < 200; i++) tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) run_line(858, 64, 1'b1, 1'b1, 858);
    chk("relock_early", 32'(locked), 32'd0);
    run_line(858, 64, 1'b1, 1'b1, 858);
    chk("relock_locked", 32'(locked), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
